regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between NREQ writeback sources (e.g. ALU, load unit, mult/div) using round-robin arbitration and a valid/ready handshake. Sits between the execute/memory writeback paths and the 32x32 register file. Registers the winning write for one cycle before it reaches the file. Suppresses writes to $zero and counts contention cycles for debug.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width
CNT_W, 16, width of saturating contention counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester write request
req_ready  out  NREQ  per-requester grant (one-hot or zero)
req_addr  in  NREQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NREQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  ADDR_W  register-file write address (registered)
rf_wdata  out  DATA_W  register-file write data (registered)
grant_id  out  $clog2(NREQ)  index of requester whose write is on rf_* this cycle (registered)
conflict_cnt  out  CNT_W  cycles with two or more valid requests, saturating

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, conflict_cnt=0, rr_ptr=0.
- While rst=1, req_ready=0 (combinational gating).
- Handshake:
  - Transfer on req_valid[i] & req_ready[i].
  - A requester holds valid, addr and data stable until ready. Dropping valid before ready is legal; the request is simply not serviced.
- Grant (combinational, same cycle):
  - Among asserted req_valid, pick the first index at or after rr_ptr, searching cyclically modulo NREQ.
  - req_ready is one-hot on the winner; all zero if no valid.
  - The port accepts one write every cycle, so there is no back-pressure beyond arbitration.
- rr_ptr update: after a grant to i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr is unchanged.
- Starvation bound: a continuously valid requester is granted within NREQ cycles.
- Output stage (latency 1): cycle after a transfer from i:
  - rf_waddr <= addr_i, rf_wdata <= data_i, grant_id <= i.
  - rf_we <= (addr_i != 0).
  - With no transfer, rf_we <= 0 and rf_waddr/rf_wdata/grant_id hold their previous values.
- $zero: an address-0 request is accepted (ready=1, rr_ptr advances) but produces no write.
- Same destination from two requesters: serviced in grant order, one per cycle; the later-granted write lands last and wins.
- conflict_cnt: increments when popcount(req_valid) >= 2 and rst=0. It saturates at 2^CNT_W-1 with no wrap.
- Reset mid-operation: a write registered in the previous cycle still appears on rf_* that cycle. rst asserted during that cycle clears rf_we on the next edge. No partial state survives reset.
- Widths: NREQ must not be a power-of-two edge case for the modulo; implement wrap with an explicit compare, not truncation.

Decomposition:
- Shared package rf_pkg: RF_ADDR_W=5, RF_DATA_W=32, RF_ZERO_ADDR=5'd0, RF_DEPTH=32.
- Sub-module rr_arbiter (params N). Inputs: req[N], ptr. Outputs: gnt[N] one-hot, gnt_id, gnt_any. Purely combinational and reusable by other shared-resource arbiters.
- Top level holds rr_ptr, the output register stage and the counter.

Test Plan:
- Reset release: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, rf_we=0, conflict_cnt=0. First cycle after release, ready=3'b001.
- Single requester: req_valid=3'b010, addr=5'd8, data=32'hDEADBEEF -> ready=3'b010 same cycle. Next cycle rf_we=1, rf_waddr=8, rf_wdata=DEADBEEF, grant_id=1.
- Round-robin: all three valid continuously for 6 cycles, distinct addrs 1/2/3 -> grant order 0,1,2,0,1,2. rf_waddr sequence 1,2,3,1,2,3 one cycle later. conflict_cnt=6.
- $zero suppression: requester 2 writes addr 0, data 32'h1234 -> ready asserted, next cycle rf_we=0. rr_ptr advances so requester 0 wins the following contention.
- Same-address ordering: requesters 0 and 1 both target addr 5 with data 32'hA and 32'hB, rr_ptr=1 -> writes B then A, final reg5=32'hA.
- Saturation/reset mid-op with CNT_W=4: hold 2 valids for 20 cycles -> conflict_cnt stops at 15. Assert rst with a write in flight -> rf_we=0 and conflict_cnt=0 after the next edge.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: register-file constants shared by the writeback arbiter and any
// other logic that addresses the 32x32 integer register file.
//
// Contents:
//   RF_ADDR_W     register address width
//   RF_DATA_W     register data width
//   RF_ZERO_ADDR  address of the hardwired-zero register ($zero)
//   RF_DEPTH      number of architectural registers
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = 5'd0;
    localparam int RF_DEPTH  = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//
// Picks the first asserted request at or after index ptr, searching
// cyclically modulo N. Intended for reuse by any shared-resource arbiter;
// the caller owns the pointer register and decides how it advances.
//
// Ports:
//   req      in   N      request vector
//   ptr      in   ID_W   highest-priority index this cycle (must be < N)
//   gnt      out  N      one-hot grant, all zero when no request
//   gnt_id   out  ID_W   index of the granted request (0 when none)
//   gnt_any  out  1      at least one request was granted
module rr_arbiter
    import rf_pkg::*;
#(
    parameter  int N    = 3,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    // One extra bit so ptr + offset cannot overflow before the wrap compare.
    localparam int IDX_W = ID_W + 1;

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + IDX_W'(k);
            // Explicit wrap: N need not be a power of two, so bit
            // truncation would land on non-existent requesters.
            if (idx >= IDX_W'(N)) begin
                idx = idx - IDX_W'(N);
            end
            if (!gnt_any && req[idx[ID_W-1:0]]) begin
                gnt_any                 = 1'b1;
                gnt_id                  = idx[ID_W-1:0];
                gnt[idx[ID_W-1:0]]      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between
// NREQ writeback sources with round-robin arbitration.
//
// Handshake: a requester raises req_valid[i] with req_addr/req_data for
// slot i and holds all three stable until it sees req_ready[i]. A transfer
// happens in any cycle where req_valid[i] & req_ready[i]. Dropping valid
// before ready is allowed and simply withdraws the request. The write port
// takes one write per cycle, so the only back-pressure is losing arbitration.
//
// The winning write is registered for one cycle before it reaches the file.
// Writes to $zero are accepted (they consume a grant) but never assert rf_we.
//
// Ports:
//   clk           in   1            rising-edge clock
//   rst           in   1            synchronous active-high reset
//   req_valid     in   NREQ         per-requester write request
//   req_ready     out  NREQ         per-requester grant, one-hot or zero
//   req_addr      in   NREQ*ADDR_W  packed addresses, slot i at [i*ADDR_W +: ADDR_W]
//   req_data      in   NREQ*DATA_W  packed data, slot i at [i*DATA_W +: DATA_W]
//   rf_we         out  1            registered register-file write enable
//   rf_waddr      out  ADDR_W       registered write address
//   rf_wdata      out  DATA_W       registered write data
//   grant_id      out  ID_W         requester whose write is on rf_* now
//   conflict_cnt  out  CNT_W        saturating count of contention cycles
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter  int NREQ   = 3,
    parameter  int ADDR_W = RF_ADDR_W,
    parameter  int DATA_W = RF_DATA_W,
    parameter  int CNT_W  = 16,
    localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [ID_W-1:0]          grant_id,
    output logic [CNT_W-1:0]         conflict_cnt
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_ptr_next;
    logic [NREQ-1:0]   arb_gnt;
    logic [ID_W-1:0]   arb_id;
    logic              arb_any;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              multi_req;

    rr_arbiter #(
        .N       (NREQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_id  (arb_id),
        .gnt_any (arb_any)
    );

    // Grants are suppressed combinationally during reset so nothing is
    // accepted that the reset would then discard.
    assign req_ready = rst ? '0 : arb_gnt;
    assign xfer      = arb_any & ~rst;

    assign win_addr  = req_addr[arb_id*ADDR_W +: ADDR_W];
    assign win_data  = req_data[arb_id*DATA_W +: DATA_W];

    // The winner gets lowest priority next time; wrap by compare since NREQ
    // is generally not a power of two.
    assign rr_ptr_next = (arb_id == ID_W'(NREQ - 1)) ? '0 : arb_id + ID_W'(1);

    // Two or more bits set <=> clearing the lowest set bit leaves something.
    assign multi_req = |(req_valid & (req_valid - NREQ'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            grant_id     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (xfer) begin
                rr_ptr   <= rr_ptr_next;
                rf_we    <= (win_addr != ADDR_W'(RF_ZERO_ADDR));
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
                grant_id <= arb_id;
            end else begin
                rf_we    <= 1'b0;
            end
            if (multi_req && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, a saturating-counter
// sequence on a narrow-counter instance, and a randomized run against a
// behavioural model of round-robin write-port sharing.
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 4;
    localparam int ID_W   = 2;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic [ID_W-1:0]        grant_id;
    logic [CNT_W-1:0]       conflict_cnt;

    regfile_wb_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id),
        .conflict_cnt(conflict_cnt)
    );

    // ---------------- narrow-counter DUT ----------------
    logic                   s_rst;
    logic [NREQ-1:0]        s_valid;
    logic [NREQ-1:0]        s_ready;
    logic [NREQ*ADDR_W-1:0] s_addr;
    logic [NREQ*DATA_W-1:0] s_data;
    logic                   s_we;
    logic [ADDR_W-1:0]      s_waddr;
    logic [DATA_W-1:0]      s_wdata;
    logic [ID_W-1:0]        s_gid;
    logic [SAT_W-1:0]       s_cnt;

    regfile_wb_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(SAT_W)
    ) dut_sat (
        .clk(clk), .rst(s_rst), .req_valid(s_valid), .req_ready(s_ready),
        .req_addr(s_addr), .req_data(s_data), .rf_we(s_we),
        .rf_waddr(s_waddr), .rf_wdata(s_wdata), .grant_id(s_gid),
        .conflict_cnt(s_cnt)
    );

    // ---------------- bookkeeping ----------------
    int vectors    = 0;
    int miscompares = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Register file as seen from the write port (bench-owned).
    logic [DATA_W-1:0] tb_rf  [RF_DEPTH];
    // Register file as the model says it should end up.
    logic [DATA_W-1:0] m_regs [RF_DEPTH];

    task automatic drive(input logic r, input logic [NREQ-1:0] v,
                         input logic [NREQ*ADDR_W-1:0] a,
                         input logic [NREQ*DATA_W-1:0] d);
        rst       = r;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        #1;
    endtask

    task automatic tick();
        if (rf_we) tb_rf[rf_waddr] = rf_wdata;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic                   rst;
        logic [NREQ-1:0]        v;
        logic [NREQ*ADDR_W-1:0] a;
        logic [NREQ*DATA_W-1:0] d;
        logic [NREQ-1:0]        ready;
        logic                   we;
        logic [ADDR_W-1:0]      waddr;
        logic [DATA_W-1:0]      wdata;
        logic [ID_W-1:0]        gid;
        logic [CNT_W-1:0]       cnt;
    } vec_t;

    vec_t tbl [20];
    int   n_rows = 0;

    task automatic add_row(input logic r, input logic [NREQ-1:0] v,
                           input logic [NREQ*ADDR_W-1:0] a,
                           input logic [NREQ*DATA_W-1:0] d,
                           input logic [NREQ-1:0] ready, input logic we,
                           input logic [ADDR_W-1:0] waddr,
                           input logic [DATA_W-1:0] wdata,
                           input logic [ID_W-1:0] gid,
                           input logic [CNT_W-1:0] cnt);
        tbl[n_rows] = '{r, v, a, d, ready, we, waddr, wdata, gid, cnt};
        n_rows++;
    endtask

    // ---------------- behavioural model ----------------
    function automatic int pick(logic [NREQ-1:0] v, int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    int                m_ptr;
    logic              m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;
    int                m_gid;
    int                m_cnt;

    logic              cur_v [NREQ];
    logic [ADDR_W-1:0] cur_a [NREQ];
    logic [DATA_W-1:0] cur_d [NREQ];
    int                waits [NREQ];
    int                max_wait;

    localparam logic [NREQ*ADDR_W-1:0] A_RR = {5'd3, 5'd2, 5'd1};
    localparam logic [NREQ*DATA_W-1:0] D_RR = {32'h102, 32'h101, 32'h100};

    initial begin
        for (int i = 0; i < RF_DEPTH; i++) begin
            tb_rf[i]  = '0;
            m_regs[i] = '0;
        end
        s_rst   = 1'b1;
        s_valid = '0;
        s_addr  = '0;
        s_data  = '0;

        // rst, v, addr, data | ready, we, waddr, wdata, gid, cnt
        add_row(1'b1, 3'b111, A_RR, D_RR, 3'b000, 1'b0, 5'd0, 32'h0,   2'd0, 16'd0);
        add_row(1'b1, 3'b111, A_RR, D_RR, 3'b000, 1'b0, 5'd0, 32'h0,   2'd0, 16'd0);
        add_row(1'b0, 3'b111, A_RR, D_RR, 3'b001, 1'b1, 5'd1, 32'h100, 2'd0, 16'd1);
        add_row(1'b0, 3'b111, A_RR, D_RR, 3'b010, 1'b1, 5'd2, 32'h101, 2'd1, 16'd2);
        add_row(1'b0, 3'b111, A_RR, D_RR, 3'b100, 1'b1, 5'd3, 32'h102, 2'd2, 16'd3);
        add_row(1'b0, 3'b111, A_RR, D_RR, 3'b001, 1'b1, 5'd1, 32'h100, 2'd0, 16'd4);
        add_row(1'b0, 3'b111, A_RR, D_RR, 3'b010, 1'b1, 5'd2, 32'h101, 2'd1, 16'd5);
        add_row(1'b0, 3'b111, A_RR, D_RR, 3'b100, 1'b1, 5'd3, 32'h102, 2'd2, 16'd6);
        // single requester
        add_row(1'b0, 3'b010, {5'd0, 5'd8, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                3'b010, 1'b1, 5'd8, 32'hDEADBEEF, 2'd1, 16'd6);
        // $zero write: accepted, no rf_we, pointer moves to 0
        add_row(1'b0, 3'b100, {5'd0, 5'd0, 5'd0}, {32'h1234, 32'h0, 32'h0},
                3'b100, 1'b0, 5'd0, 32'h1234, 2'd2, 16'd6);
        add_row(1'b0, 3'b101, {5'd9, 5'd0, 5'd4}, {32'h99, 32'h0, 32'h44},
                3'b001, 1'b1, 5'd4, 32'h44, 2'd0, 16'd7);
        // same destination, pointer at 1: B lands first, then A
        add_row(1'b0, 3'b011, {5'd0, 5'd5, 5'd5}, {32'h0, 32'hB, 32'hA},
                3'b010, 1'b1, 5'd5, 32'hB, 2'd1, 16'd8);
        add_row(1'b0, 3'b001, {5'd0, 5'd5, 5'd5}, {32'h0, 32'hB, 32'hA},
                3'b001, 1'b1, 5'd5, 32'hA, 2'd0, 16'd8);
        // idle: registers hold, we drops
        add_row(1'b0, 3'b000, '0, '0, 3'b000, 1'b0, 5'd5, 32'hA, 2'd0, 16'd8);
        // reset with a write in flight, then restart from pointer 0
        add_row(1'b0, 3'b111, A_RR, D_RR, 3'b010, 1'b1, 5'd2, 32'h101, 2'd1, 16'd9);
        add_row(1'b1, 3'b111, A_RR, D_RR, 3'b000, 1'b0, 5'd0, 32'h0,   2'd0, 16'd0);
        add_row(1'b0, 3'b111, A_RR, D_RR, 3'b001, 1'b1, 5'd1, 32'h100, 2'd0, 16'd1);

        for (int i = 0; i < n_rows; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].d);
            check("tbl_ready", 64'(req_ready), 64'(tbl[i].ready));
            tick();
            check("tbl_we",    64'(rf_we),        64'(tbl[i].we));
            check("tbl_waddr", 64'(rf_waddr),     64'(tbl[i].waddr));
            check("tbl_wdata", 64'(rf_wdata),     64'(tbl[i].wdata));
            check("tbl_gid",   64'(grant_id),     64'(tbl[i].gid));
            check("tbl_cnt",   64'(conflict_cnt), 64'(tbl[i].cnt));
        end
        check("reg5_last_wins", 64'(tb_rf[5]), 64'(32'hA));
        check("reg0_untouched", 64'(tb_rf[0]), 64'(0));

        // ---------------- saturation and reset mid-operation ----------------
        drive(1'b0, '0, '0, '0);
        s_rst   = 1'b1;
        s_valid = 3'b011;
        s_addr  = {5'd0, 5'd7, 5'd3};
        s_data  = {32'h0, 32'h77, 32'h33};
        tick();
        tick();
        check("sat_rst_ready", 64'(s_ready), 64'(0));
        check("sat_rst_cnt",   64'(s_cnt),   64'(0));
        s_rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            check("sat_ready", 64'(s_ready), (k % 2 == 1) ? 64'(3'b001) : 64'(3'b010));
            tick();
            check("sat_cnt", 64'(s_cnt), 64'((k > 15) ? 15 : k));
        end
        check("sat_inflight_we",    64'(s_we),    64'(1));
        check("sat_inflight_waddr", 64'(s_waddr), 64'(7));
        s_rst = 1'b1;
        #1;
        check("sat_rst_gates_ready", 64'(s_ready), 64'(0));
        check("sat_rst_we_visible",  64'(s_we),    64'(1));
        tick();
        check("sat_post_rst_we",    64'(s_we),    64'(0));
        check("sat_post_rst_cnt",   64'(s_cnt),   64'(0));
        check("sat_post_rst_waddr", 64'(s_waddr), 64'(0));
        check("sat_post_rst_gid",   64'(s_gid),   64'(0));
        s_rst = 1'b0;
        #1;
        check("sat_restart_ready", 64'(s_ready), 64'(3'b001));
        s_valid = '0;

        // ---------------- randomized run vs model ----------------
        drive(1'b1, '0, '0, '0);
        tick();
        tick();
        for (int i = 0; i < RF_DEPTH; i++) begin
            tb_rf[i]  = '0;
            m_regs[i] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            cur_v[i] = 1'b0;
            cur_a[i] = '0;
            cur_d[i] = '0;
            waits[i] = 0;
        end
        max_wait = 0;
        m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = 0; m_cnt = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            logic                   r;
            logic [NREQ-1:0]        pv;
            logic [NREQ*ADDR_W-1:0] pa;
            logic [NREQ*DATA_W-1:0] pd;
            logic [NREQ-1:0]        exp_ready;
            int                     w;

            r = (cyc < 2) || ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NREQ; i++) begin
                pv[i]                  = cur_v[i];
                pa[i*ADDR_W +: ADDR_W] = cur_a[i];
                pd[i*DATA_W +: DATA_W] = cur_d[i];
            end
            drive(r, pv, pa, pd);

            w = r ? -1 : pick(pv, m_ptr);
            exp_ready = (w < 0) ? '0 : (NREQ'(1) << w);
            check("rand_ready", 64'(req_ready), 64'(exp_ready));

            for (int i = 0; i < NREQ; i++) begin
                if (r || !cur_v[i] || req_ready[i]) waits[i] = 0;
                else waits[i]++;
                if (waits[i] > max_wait) max_wait = waits[i];
            end

            tick();

            if (r) begin
                m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = 0; m_cnt = 0;
            end else begin
                if (w >= 0) begin
                    m_we    = (cur_a[w] != 0);
                    m_waddr = cur_a[w];
                    m_wdata = cur_d[w];
                    m_gid   = w;
                    m_ptr   = (w + 1) % NREQ;
                    if (cur_a[w] != 0) m_regs[cur_a[w]] = cur_d[w];
                end else begin
                    m_we = 1'b0;
                end
                if ($countones(pv) >= 2 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end

            check("rand_we",    64'(rf_we),        64'(m_we));
            check("rand_waddr", 64'(rf_waddr),     64'(m_waddr));
            check("rand_wdata", 64'(rf_wdata),     64'(m_wdata));
            check("rand_gid",   64'(grant_id),     64'(m_gid));
            check("rand_cnt",   64'(conflict_cnt), 64'(m_cnt));

            // Next requests: a served requester may issue a fresh write, a
            // waiting one holds (or occasionally withdraws), an idle one may start.
            for (int i = 0; i < NREQ; i++) begin
                if (cur_v[i] && (w == i)) begin
                    cur_v[i] = ($urandom_range(0, 3) != 0);
                    cur_a[i] = ADDR_W'($urandom_range(0, 7));
                    cur_d[i] = $urandom;
                end else if (cur_v[i]) begin
                    if ($urandom_range(0, 9) == 0) cur_v[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 0) begin
                    cur_v[i] = 1'b1;
                    cur_a[i] = ADDR_W'($urandom_range(0, 7));
                    cur_d[i] = $urandom;
                end
            end
        end

        drive(1'b0, '0, '0, '0);
        tick();
        tick();
        check("starve_bound", 64'(max_wait <= NREQ - 1), 64'(1));
        for (int i = 0; i < RF_DEPTH; i++) begin
            check("rand_regfile", 64'(tb_rf[i]), 64'(m_regs[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
